mul_share_ctrl: RTL and testbench

//  Sequencer and round-robin arbiter that shares one add-and-decrement multiplier datapath among NREQ requesters.
//  - Datapath: A reg, B down-counter with eqz flag, D accumulator.
//  - Grants one requester, steers its operands through sel, strobes ld_a/ld_b/clr_d/ld_d/dec.
//  - Pulses done[owner] once the product in D is valid.
//  - Sits between requesting engines and the shared multiplier.

---
 rtl/mul_share_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_share_ctrl                                                |
// | Purpose  : Sequencer and arbiter that shares one add-and-decrement       |
// |            multiplier datapath (A reg, B down-counter, D accumulator)    |
// |            among NREQ requesters. Grants one owner at a time, steers its |
// |            operands via sel_o, strobes the datapath and pulses           |
// |            done_o[owner] once D holds the product.                       |
// | Ports    : clk_i      system clock, rising edge                          |
// |            rst_ni     asynchronous active-low reset                      |
// |            req_i      request per requester, held until done            |
// |            gnt_o      one-hot grant to current owner                     |
// |            done_o     1-cycle pulse to owner, product valid in D         |
// |            busy_o     high whenever not idle                             |
// |            owner_o    index of current owner                             |
// |            sel_o      datapath operand-mux select (equals owner)         |
// |            ld_a_o     load A from selected a operand                     |
// |            ld_b_o     load B counter from selected b operand             |
// |            clr_d_o    clear accumulator D                                |
// |            ld_d_o     D <= D + A                                         |
// |            dec_o      B <= B - 1                                         |
// |            eqz_i      B counter == 0 flag from datapath                  |
// | Config   : MUL_FIXED_PRIO_EN defined -> fixed priority (lowest index     |
// |            wins); undefined (default) -> round-robin arbitration.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mul_share_ctrl #(
  parameter  int NREQ = 4,
  parameter  int W    = 16,
  localparam int SELW = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] done_o,
  output logic            busy_o,
  output logic [SELW-1:0] owner_o,
  output logic [SELW-1:0] sel_o,
  output logic            ld_a_o,
  output logic            ld_b_o,
  output logic            clr_d_o,
  output logic            ld_d_o,
  output logic            dec_o,
  input  logic            eqz_i
);

  // Parameter legality is checked at elaboration; W only sizes the
  // external datapath and is otherwise informational here.
  if (NREQ < 2 || NREQ > 8 || W < 1) begin : g_param_check
    $error("mul_share_ctrl: NREQ must be 2..8 and W >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ACC  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e            state_q;
  logic [SELW-1:0]   owner_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              busy_q;
  logic              ld_a_q;
  logic              ld_b_q;
  logic              clr_d_q;

  // Arbitration result for the current req_i, only consumed in S_IDLE.
  logic [SELW-1:0]   win;
  logic              win_vld;

`ifdef MUL_FIXED_PRIO_EN
  // Fixed priority: scan from the top down so the lowest active index
  // is the last (and therefore final) assignment.
  always_comb begin : p_arb
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        win     = SELW'(k);
        win_vld = 1'b1;
      end
    end
  end
`else
  // Round-robin pointer: index of the most recent winner. Search starts
  // one past it so the last winner has the lowest priority next time.
  logic [SELW-1:0]   ptr_q;

  always_comb begin : p_arb
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_vld && req_i[idx]) begin
        win     = SELW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= SELW'(NREQ - 1);
    end else if (state_q == S_IDLE && win_vld) begin
      ptr_q <= win;
    end
  end
`endif

  // Sequencer. Outputs are computed for the state being entered so they
  // appear registered, in step with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      clr_d_q <= 1'b0;
    end else begin
      done_q  <= '0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      clr_d_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q <= S_LDA;
            owner_q <= win;
            gnt_q   <= NREQ'(1) << win;
            busy_q  <= 1'b1;
            ld_a_q  <= 1'b1;
          end
        end
        S_LDA: begin
          state_q <= S_LDB;
          ld_b_q  <= 1'b1;
          clr_d_q <= 1'b1;
        end
        S_LDB: begin
          state_q <= S_ACC;
        end
        S_ACC: begin
          // B has reached zero: D now holds A*B, report it.
          if (eqz_i) begin
            state_q <= S_FIN;
            done_q  <= NREQ'(1) << owner_q;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Accumulate/decrement is Mealy on eqz_i so a zero B never adds, and
  // exactly B add cycles occur for a nonzero B.
  assign ld_d_o  = (state_q == S_ACC) && !eqz_i;
  assign dec_o   = (state_q == S_ACC) && !eqz_i;

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign owner_o = owner_q;
  assign sel_o   = owner_q;
  assign ld_a_o  = ld_a_q;
  assign ld_b_o  = ld_b_q;
  assign clr_d_o = clr_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_share_ctrl                                             |
// | Purpose  : Directed self-checking bench for mul_share_ctrl with a small  |
// |            behavioural A/B/D datapath driven by the DUT strobes.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mul_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt, done;
  logic       busy;
  logic [1:0] owner, sel;
  logic       ld_a, ld_b, clr_d, ld_d, dec, eqz;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural shared datapath with per-requester operands.
  logic [15:0] a_op [4];
  logic [15:0] b_op [4];
  logic [15:0] A_r = '0;
  logic [15:0] B_r = '0;
  logic [15:0] D_r = '0;

  // Hand-computed per-requester B values and products a*b.
  int exp_b [4] = '{3, 2, 0, 1};
  int exp_d [4] = '{15, 8, 0, 6};

  always #5 clk = ~clk;

  mul_share_ctrl #(.NREQ(4), .W(16)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .done_o  (done),
    .busy_o  (busy),
    .owner_o (owner),
    .sel_o   (sel),
    .ld_a_o  (ld_a),
    .ld_b_o  (ld_b),
    .clr_d_o (clr_d),
    .ld_d_o  (ld_d),
    .dec_o   (dec),
    .eqz_i   (eqz)
  );

  always @(posedge clk) begin
    if (ld_a)  A_r <= a_op[sel];
    if (ld_b)  B_r <= b_op[sel];
    if (dec)   B_r <= B_r - 16'd1;
    if (clr_d) D_r <= '0;
    if (ld_d)  D_r <= D_r + A_r;
  end
  assign eqz = (B_r == 16'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full job from IDLE: request rv, expect exp_own to win, follow it
  // to done and back to IDLE.
  task automatic job(input logic [3:0] rv, input int exp_own);
    int e;
    int nldd;
    req = rv;
    tick();  // edge 0
    check_eq("gnt", gnt, 32'(1) << exp_own);
    check_eq("owner", owner, exp_own);
    check_eq("sel", sel, exp_own);
    check_eq("ld_a", ld_a, 1);
    check_eq("busy", busy, 1);
    tick();  // edge 1
    check_eq("ld_b", ld_b, 1);
    check_eq("clr_d", clr_d, 1);
    check_eq("ld_a_off", ld_a, 0);
    tick();  // edge 2
    e    = -1;
    nldd = 0;
    for (int k = 3; k <= 40; k++) begin
      if (ld_d === 1'b1) nldd++;
      check_eq("ld_d_eq_dec", ld_d, dec);
      tick();
      if (done !== 4'b0) begin
        e = k;
        break;
      end
    end
    check_eq("done_edge", e, exp_b[exp_own] + 3);
    check_eq("done", done, 32'(1) << exp_own);
    check_eq("ld_d_cnt", nldd, exp_b[exp_own]);
    check_eq("D", D_r, exp_d[exp_own]);
    tick();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_gnt", gnt, 0);
    check_eq("idle_done", done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [5];
    int e;
`ifdef MUL_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    a_op = '{16'd5, 16'd4, 16'd7, 16'd6};
    b_op = '{16'd3, 16'd2, 16'd0, 16'd1};

    // Reset state with all requests active.
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_strb", {ld_a, ld_b, clr_d, ld_d, dec}, 0);
    rst_n = 1'b1;
    job(4'b1111, 0);

    // Single requester, 5*3 and a zero-B job.
    job(4'b0001, 0);
    job(4'b0100, 2);

    // Arbitration order with all requests held.
    do_reset();
    for (int i = 0; i < 5; i++) job(4'b1111, ord[i]);

    // Reset in the middle of an accumulate aborts with no done.
    b_op[0] = 16'd10;
    req = 4'b0001;
    repeat (5) tick();  // edges 0..4, now in ACC
    check_eq("abort_pre_ld_d", ld_d, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_gnt", gnt, 0);
    check_eq("abort_strb", {ld_a, ld_b, clr_d, ld_d, dec}, 0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    check_eq("abort_done", done, 0);
    b_op[0] = 16'd3;
    job(4'b0010, 1);

    // Owner drops req mid-job; another request arrives during FIN.
    req = 4'b0001;
    tick();  // edge 0
    check_eq("drop_gnt", gnt, 4'b0001);
    tick();
    tick();
    req = 4'b0000;
    e = -1;
    for (int k = 3; k <= 40; k++) begin
      tick();
      if (done !== 4'b0) begin
        e = k;
        break;
      end
    end
    check_eq("drop_done_edge", e, 6);
    check_eq("drop_done", done, 4'b0001);
    check_eq("drop_D", D_r, 15);
    req = 4'b1000;
    tick();
    check_eq("gap_busy", busy, 0);
    check_eq("gap_gnt", gnt, 0);
    tick();
    check_eq("next_gnt", gnt, 4'b1000);
    check_eq("next_owner", owner, 3);
    repeat (8) tick();
    req = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
